// File: rtl/dc_fu_dma_pkg.sv
// Shared types and width helpers for the fetching-unit DMA progress tracker.
package dc_fu_dma_pkg;

    localparam int unsigned FETCH_WORD_COUNT_WIDTH_DEFAULT = 16;

    typedef logic [FETCH_WORD_COUNT_WIDTH_DEFAULT-1:0] word_count_t;

    // Enough bits to count a full queue plus the active request.
    function automatic int unsigned out_cnt_width(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 2);
    endfunction

endpackage

// File: rtl/dc_fu_dma_req_fifo.sv
// Synchronous request FIFO with full/empty flags, occupancy count and head peek.
// DEPTH must be a power of two so the pointers wrap naturally.
module dc_fu_dma_req_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_r;
    logic [PTR_WIDTH-1:0]  rd_ptr_r;
    logic [CNT_WIDTH-1:0]  cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
            end
            cnt_r <= cnt_r + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

    // Storage needs no reset; occupancy alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_r] <= push_data;
        end
    end

    assign count = cnt_r;
    assign full  = (cnt_r == CNT_WIDTH'(DEPTH));
    assign empty = (cnt_r == '0);
    assign head  = mem[rd_ptr_r];

endmodule

// File: rtl/dc_fu_dma_fetch_progress_tracker.sv
// Multi-request fetch progress tracker: queues word counts and retires them against R beats.
// Optional R-channel last-beat checking is enabled by defining DC_FU_DMA_RLAST_CHECK_EN.
module dc_fu_dma_fetch_progress_tracker
    import dc_fu_dma_pkg::*;
#(
    parameter int unsigned FETCH_WORD_COUNT_WIDTH = FETCH_WORD_COUNT_WIDTH_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING        = 4,
    parameter int unsigned OUT_CNT_WIDTH          = out_cnt_width(MAX_OUTSTANDING)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              start_fetch,
    input  logic [FETCH_WORD_COUNT_WIDTH-1:0] fetch_word_count,
    output logic                              start_ready,
    input  logic                              axi_rvalid,
    input  logic                              axi_rready,
    input  logic                              axi_rlast,
    output logic                              fetch_in_progress,
    output logic [OUT_CNT_WIDTH-1:0]          outstanding_cnt,
    output logic [FETCH_WORD_COUNT_WIDTH-1:0] words_remaining,
    output logic                              fetch_done,
    output logic                              req_overflow,
    output logic                              protocol_err
);

    localparam int unsigned Q_CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [FETCH_WORD_COUNT_WIDTH-1:0] ONE = FETCH_WORD_COUNT_WIDTH'(1);

    logic [FETCH_WORD_COUNT_WIDTH-1:0] cnt_r;
    logic [FETCH_WORD_COUNT_WIDTH-1:0] cnt_d;
    logic [FETCH_WORD_COUNT_WIDTH-1:0] cur;
    logic [FETCH_WORD_COUNT_WIDTH-1:0] q_head;
    logic [Q_CNT_WIDTH-1:0]            q_count;
    logic                              q_full;
    logic                              q_empty;
    logic                              done_r;
    logic                              done_d;
    logic                              overflow_r;
    logic                              beat;
    logic                              active;
    logic                              pop;
    logic                              push_req;
    logic                              push_accept;
    logic                              push_drop;

    assign beat     = axi_rvalid && axi_rready && en;
    assign active   = (cnt_r != '0);
    assign cur      = active ? cnt_r : (q_empty ? '0 : q_head);
    assign push_req = start_fetch && en && (fetch_word_count != '0);

    always_comb begin
        pop    = 1'b0;
        cnt_d  = cnt_r;
        done_d = 1'b0;
        if (beat && (cur != '0)) begin
            // A beat against an unloaded head consumes that head directly.
            if (!active) begin
                pop = 1'b1;
            end
            if (cur > ONE) begin
                cnt_d = cur - ONE;
            end else begin
                done_d = 1'b1;
                // Chain straight into the next request so no beat slot is lost.
                if (active && !q_empty) begin
                    pop   = 1'b1;
                    cnt_d = q_head;
                end else begin
                    cnt_d = '0;
                end
            end
        end else if (en && !beat && !active && !q_empty) begin
            pop   = 1'b1;
            cnt_d = q_head;
        end
    end

    // A full queue still takes a push when the same cycle frees a slot.
    assign push_accept = push_req && (!q_full || pop);
    assign push_drop   = push_req && q_full && !pop;

    dc_fu_dma_req_fifo #(
        .DATA_WIDTH (FETCH_WORD_COUNT_WIDTH),
        .DEPTH      (MAX_OUTSTANDING),
        .CNT_WIDTH  (Q_CNT_WIDTH)
    ) u_req_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_accept),
        .push_data  (fetch_word_count),
        .pop        (pop),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count),
        .head       (q_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_d;
            done_r <= done_d;
            if (push_drop) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef DC_FU_DMA_RLAST_CHECK_EN
    logic rlast_err;
    logic perr_r;

    always_comb begin
        rlast_err = 1'b0;
        if (beat) begin
            if (cur == '0) begin
                rlast_err = 1'b1;
            end else if (cur == ONE) begin
                rlast_err = !axi_rlast;
            end else begin
                rlast_err = axi_rlast;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_r <= 1'b0;
        end else if (rlast_err) begin
            perr_r <= 1'b1;
        end
    end

    assign protocol_err = perr_r;
`else
    logic unused_rlast;
    assign unused_rlast = axi_rlast;
    assign protocol_err = 1'b0;
`endif

    assign start_ready       = !q_full;
    assign fetch_in_progress = active || !q_empty;
    assign outstanding_cnt   = OUT_CNT_WIDTH'(q_count) + OUT_CNT_WIDTH'(active);
    assign words_remaining   = cnt_r;
    assign fetch_done        = done_r;
    assign req_overflow      = overflow_r;

endmodule
